// File: rtl/flush_broadcaster.sv
// Flush fan-out from the reorder buffer: one registered flush pulse per enabled consumer,
// then ack collection with a timeout, then a single redirect to the fetcher.
module flush_broadcaster #(
    parameter int NUM_CH     = 6,
    parameter int PC_WIDTH   = 32,
    parameter int DEST_WIDTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_req_in,
    input  logic [PC_WIDTH-1:0]   flush_pc_in,
    input  logic [DEST_WIDTH-1:0] flush_dest_in,
    output logic                  flush_ready_out,
    input  logic [NUM_CH-1:0]     ch_enable_in,
    output logic [NUM_CH-1:0]     flush_out,
    output logic [DEST_WIDTH-1:0] flush_dest_out,
    input  logic [NUM_CH-1:0]     ack_in,
    output logic                  redirect_valid_out,
    output logic [PC_WIDTH-1:0]   redirect_pc_out,
    output logic                  stall_out,
    output logic [NUM_CH-1:0]     timeout_mask_out,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BCAST    = 2'd1,
        S_DRAIN    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [DEST_WIDTH-1:0]   dest_q;
    logic [NUM_CH-1:0]       en_q;
    logic [NUM_CH-1:0]       ack_q;
    logic [NUM_CH-1:0]       tmask_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CH-1:0]       ack_merged;
    logic                    all_acked;
    logic                    cnt_expired;
    logic                    accept;

    // Handshake: a request is taken on any cycle where flush_req_in, flush_ready_out and
    // rdy_in are all high; there is no buffering, so a request seen while busy is dropped.
    assign accept      = (state_q == S_IDLE) && flush_req_in && rdy_in;
    assign ack_merged  = ack_q | (ack_in & en_q);
    assign all_acked   = &ack_merged;
    assign cnt_expired = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req_in) begin
                    state_d = S_BCAST;
                end
            end
            S_BCAST: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (all_acked || cnt_expired) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latches, ack vector and drain counter; all hold while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q    <= '0;
            dest_q  <= '0;
            en_q    <= '0;
            ack_q   <= '0;
            tmask_q <= '0;
            cnt_q   <= '0;
        end else if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        pc_q    <= flush_pc_in;
                        dest_q  <= flush_dest_in;
                        en_q    <= ch_enable_in;
                        ack_q   <= ~ch_enable_in;
                        tmask_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_BCAST: begin
                    ack_q <= ack_merged;
                    cnt_q <= '0;
                end
                S_DRAIN: begin
                    ack_q <= ack_merged;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Laggards are those still missing after this cycle's acks are folded in.
                    if (!all_acked && cnt_expired) begin
                        tmask_q <= ~ack_merged;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; pulses are suppressed while the pipeline is frozen and replay once it resumes.
    always_comb begin
        flush_ready_out    = (state_q == S_IDLE);
        stall_out          = (state_q != S_IDLE);
        flush_out          = '0;
        redirect_valid_out = 1'b0;
        if (rdy_in && (state_q == S_BCAST)) begin
            flush_out = en_q;
        end
        if (rdy_in && (state_q == S_REDIRECT)) begin
            redirect_valid_out = 1'b1;
        end
    end

    assign flush_dest_out   = dest_q;
    assign redirect_pc_out  = pc_q;
    assign timeout_mask_out = tmask_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_flush_broadcaster.sv
// Directed bench for flush_broadcaster: stimulus schedules expected pulses and status levels
// by cycle number; an independent monitor compares them as the DUT presents them.
module tb_flush_broadcaster;

    localparam int NUM_CH     = 6;
    localparam int PC_WIDTH   = 32;
    localparam int DEST_WIDTH = 4;
    localparam int TIMEOUT    = 15;
    localparam int W          = 64;

    localparam logic [7:0] K_FLUSH = 8'd1;
    localparam logic [7:0] K_REDIR = 8'd2;
    localparam logic [7:0] F_STALL = 8'd1;
    localparam logic [7:0] F_READY = 8'd2;
    localparam logic [7:0] F_TMASK = 8'd3;
    localparam logic [7:0] F_FLUSH = 8'd4;
    localparam logic [7:0] F_DEST  = 8'd5;

    logic                  clk;
    logic                  rst;
    logic                  rdy;
    logic                  flush_req;
    logic [PC_WIDTH-1:0]   flush_pc;
    logic [DEST_WIDTH-1:0] flush_dest;
    logic                  flush_ready_out;
    logic [NUM_CH-1:0]     ch_enable;
    logic [NUM_CH-1:0]     flush_out;
    logic [DEST_WIDTH-1:0] flush_dest_out;
    logic [NUM_CH-1:0]     ack;
    logic                  redirect_valid_out;
    logic [PC_WIDTH-1:0]   redirect_pc_out;
    logic                  stall_out;
    logic [NUM_CH-1:0]     timeout_mask_out;
    logic [1:0]            state_dbg;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] stat_q[$];
    logic [W-1:0] mon_e;
    logic [31:0]  mon_act;
    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;
    bit done   = 1'b0;
    int t0;

    flush_broadcaster #(
        .NUM_CH(NUM_CH), .PC_WIDTH(PC_WIDTH), .DEST_WIDTH(DEST_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .rdy_in(rdy),
        .flush_req_in(flush_req),
        .flush_pc_in(flush_pc),
        .flush_dest_in(flush_dest),
        .flush_ready_out(flush_ready_out),
        .ch_enable_in(ch_enable),
        .flush_out(flush_out),
        .flush_dest_out(flush_dest_out),
        .ack_in(ack),
        .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out),
        .stall_out(stall_out),
        .timeout_mask_out(timeout_mask_out),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] pack(input logic [7:0] k, input int c, input logic [31:0] d);
        return {k, 24'(c), d};
    endfunction

    function automatic logic [31:0] field_val(input logic [7:0] f);
        case (f)
            F_STALL: return 32'(stall_out);
            F_READY: return 32'(flush_ready_out);
            F_TMASK: return 32'(timeout_mask_out);
            F_FLUSH: return 32'(flush_out);
            F_DEST:  return 32'(flush_dest_out);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string field_name(input logic [7:0] f);
        case (f)
            F_STALL: return "stall_out";
            F_READY: return "flush_ready_out";
            F_TMASK: return "timeout_mask_out";
            F_FLUSH: return "flush_out_level";
            F_DEST:  return "flush_dest_out";
            default: return "unknown";
        endcase
    endfunction

    // Scoreboard: pop one expected pulse per observed pulse.
    task automatic sb_pulse(input logic [W-1:0] got, input string name);
        logic [W-1:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected pulse at cycle %0d data 0x%0h, required no pulse",
                     name, got[55:32], got[31:0]);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got kind %0d cycle %0d data 0x%0h, required kind %0d cycle %0d data 0x%0h",
                         name, got[63:56], got[55:32], got[31:0], exp[63:56], exp[55:32], exp[31:0]);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!done) begin
            if (flush_out != '0) sb_pulse(pack(K_FLUSH, cyc, 32'(flush_out)), "flush_pulse");
            if (redirect_valid_out) sb_pulse(pack(K_REDIR, cyc, redirect_pc_out), "redirect");
            while (stat_q.size() != 0 && int'(stat_q[0][55:32]) <= cyc) begin
                mon_e   = stat_q.pop_front();
                mon_act = field_val(mon_e[63:56]);
                n_cmp++;
                if (int'(mon_e[55:32]) != cyc || mon_act !== mon_e[31:0]) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got 0x%0h, required 0x%0h at cycle %0d",
                             field_name(mon_e[63:56]), cyc, mon_act, mon_e[31:0], mon_e[55:32]);
                end
            end
        end else begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_pulses: %0d expected pulses never seen, required 0", exp_q.size());
            end
            n_cmp++;
            if (stat_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_status: %0d status checks never reached, required 0", stat_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic exp_p(input logic [7:0] k, input int rel, input logic [31:0] d);
        exp_q.push_back(pack(k, t0 + rel, d));
    endtask

    task automatic exp_s(input logic [7:0] f, input int rel, input logic [31:0] v);
        stat_q.push_back(pack(f, t0 + rel, v));
    endtask

    // Request during cycle t0; returns one cycle later with the request dropped.
    task automatic issue(input logic [PC_WIDTH-1:0] pc, input logic [DEST_WIDTH-1:0] dest,
                         input logic [NUM_CH-1:0] en);
        flush_req  = 1'b1;
        flush_pc   = pc;
        flush_dest = dest;
        ch_enable  = en;
        tick();
        flush_req  = 1'b0;
        ch_enable  = '0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush_req = 1'b0; flush_pc = '0;
        flush_dest = '0; ch_enable = '0; ack = '0;
        ticks(3);
        rst = 1'b0;

        // Reset state
        t0 = cyc;
        exp_s(F_READY, 0, 32'd1);
        exp_s(F_STALL, 0, 32'd0);
        exp_s(F_TMASK, 0, 32'd0);
        exp_s(F_DEST,  0, 32'd0);
        ticks(2);

        // All channels ack at T+2: earliest redirect
        t0 = cyc;
        issue(32'h1000, 4'd3, 6'h3F);
        exp_p(K_FLUSH, 1, 32'h3F);
        exp_s(F_STALL, 1, 32'd1);
        exp_s(F_DEST,  1, 32'd3);
        exp_s(F_STALL, 3, 32'd1);
        exp_s(F_STALL, 4, 32'd0);
        exp_s(F_READY, 4, 32'd1);
        exp_p(K_REDIR, 3, 32'h1000);
        tick(); ack = 6'h3F;
        tick(); ack = '0;
        ticks(3);

        // ch2 never acks: forced completion after TIMEOUT drain cycles
        t0 = cyc;
        issue(32'h2000, 4'd5, 6'h3F);
        exp_p(K_FLUSH, 1, 32'h3F);
        exp_s(F_TMASK, 1,  32'h00);
        exp_s(F_TMASK, 16, 32'h00);
        exp_s(F_TMASK, 17, 32'h04);
        exp_s(F_STALL, 17, 32'd1);
        exp_s(F_READY, 18, 32'd1);
        exp_s(F_TMASK, 20, 32'h04);
        exp_p(K_REDIR, 17, 32'h2000);
        tick(); ack = 6'h3B;
        tick(); ack = '0;
        ticks(19);

        // Staggered acks; mask is sticky up to the accept and cleared after it
        t0 = cyc;
        exp_s(F_TMASK, 0, 32'h04);
        issue(32'h3000, 4'd9, 6'h3F);
        exp_p(K_FLUSH, 1, 32'h3F);
        exp_s(F_TMASK, 1, 32'h00);
        exp_s(F_STALL, 8, 32'd1);
        exp_s(F_TMASK, 9, 32'h00);
        exp_s(F_READY, 9, 32'd1);
        exp_p(K_REDIR, 8, 32'h3000);
        ack = 6'h01;
        tick(); ack = '0;
        tick(); ack = 6'h1E;
        tick(); ack = '0;
        ticks(3); ack = 6'h20;
        tick(); ack = '0;
        ticks(3);

        // No channels enabled: no flush pulse, redirect at T+3
        t0 = cyc;
        issue(32'h4000, 4'd7, 6'h00);
        exp_s(F_STALL, 1, 32'd1);
        exp_s(F_FLUSH, 1, 32'h00);
        exp_s(F_DEST,  1, 32'd7);
        exp_s(F_READY, 4, 32'd1);
        exp_p(K_REDIR, 3, 32'h4000);
        ticks(5);

        // Request while busy is dropped; reset mid-drain aborts without redirect
        t0 = cyc;
        issue(32'h5000, 4'd1, 6'h3F);
        exp_p(K_FLUSH, 1, 32'h3F);
        exp_s(F_READY, 1, 32'd0);
        exp_s(F_READY, 2, 32'd0);
        exp_s(F_READY, 3, 32'd1);
        exp_s(F_STALL, 3, 32'd0);
        exp_s(F_DEST,  3, 32'd0);
        flush_req = 1'b1; flush_pc = 32'h0BAD; ch_enable = 6'h3F;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; flush_req = 1'b0; ch_enable = '0;
        ticks(6);

        // rdy_in low for three cycles starting at T+1: pulse deferred, acks ignored while frozen
        t0 = cyc;
        issue(32'h6000, 4'd2, 6'h3F);
        exp_s(F_STALL, 1, 32'd1);
        exp_s(F_FLUSH, 1, 32'h00);
        exp_s(F_FLUSH, 2, 32'h00);
        exp_s(F_STALL, 2, 32'd1);
        exp_s(F_FLUSH, 3, 32'h00);
        exp_s(F_DEST,  3, 32'd2);
        exp_s(F_READY, 8, 32'd1);
        exp_p(K_FLUSH, 4, 32'h3F);
        exp_p(K_REDIR, 7, 32'h6000);
        rdy = 1'b0;
        tick(); ack = 6'h01;
        tick(); ack = '0;
        tick(); rdy = 1'b1;
        tick(); ack = 6'h3E;
        tick(); ack = 6'h01;
        tick(); ack = '0;
        ticks(4);

        done = 1'b1;
        ticks(3);
        $display("FAIL monitor: summary not reached, required report after done");
        $fatal(1);
    end

endmodule
